// File: rtl/kernel_coeff_buffer.sv
// Coefficient store for the 1D convolution datapath: loads TAPS words over a
// valid/ready port, then streams them cyclically with first/last tap markers.
module kernel_coeff_buffer #(
  parameter int DATA_W  = 32,
  parameter int TAPS    = 3,
  parameter int REVERSE = 0,
  localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic signed [DATA_W-1:0] load_data,
  output logic                     load_ready,
  input  logic                     stream_en,
  output logic signed [DATA_W-1:0] coef_out,
  output logic                     coef_valid,
  output logic                     coef_first,
  output logic                     coef_last,
  output logic [TAP_W-1:0]         tap_idx,
  output logic                     kernel_ready
);

  localparam logic [TAP_W-1:0] LAST_SLOT = TAP_W'(TAPS - 1);
  localparam logic [TAP_W-1:0] START_IDX = (REVERSE != 0) ? LAST_SLOT : {TAP_W{1'b0}};
  localparam logic [TAP_W-1:0] END_IDX   = (REVERSE != 0) ? {TAP_W{1'b0}} : LAST_SLOT;

  typedef enum logic {LOAD, STREAM} state_t;

  state_t                     state;
  logic [TAP_W-1:0]           wr_ptr;
  logic [TAP_W-1:0]           rd_ptr;
  logic signed [DATA_W-1:0]   mem [TAPS];
  logic                       kernel_rdy;

  logic signed [DATA_W-1:0]   coef_p1;
  logic [TAP_W-1:0]           idx_p1;
  logic                       vld_p1;
  logic                       first_p1;
  logic                       last_p1;

  // Read pointer walks in stream order and wraps at the kernel boundary.
  function automatic logic [TAP_W-1:0] step_ptr(input logic [TAP_W-1:0] p);
    if (REVERSE != 0)
      return (p == {TAP_W{1'b0}}) ? LAST_SLOT : p - TAP_W'(1);
    else
      return (p == LAST_SLOT) ? {TAP_W{1'b0}} : p + TAP_W'(1);
  endfunction

  assign load_ready = (state == LOAD) && !reset;

  // Stage p1: registered coefficient read, one cycle after stream_en
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= START_IDX;
      kernel_rdy <= 1'b0;
      coef_p1    <= '0;
      idx_p1     <= '0;
      vld_p1     <= 1'b0;
      first_p1   <= 1'b0;
      last_p1    <= 1'b0;
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
    end else if (load_start) begin
      state      <= LOAD;
      wr_ptr     <= '0;
      rd_ptr     <= START_IDX;
      kernel_rdy <= 1'b0;
      vld_p1     <= 1'b0;
      first_p1   <= 1'b0;
      last_p1    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          vld_p1   <= 1'b0;
          first_p1 <= 1'b0;
          last_p1  <= 1'b0;
          if (load_valid) begin
            mem[wr_ptr] <= load_data;
            if (wr_ptr == LAST_SLOT) begin
              state      <= STREAM;
              kernel_rdy <= 1'b1;
              rd_ptr     <= START_IDX;
              wr_ptr     <= '0;
            end else begin
              wr_ptr <= wr_ptr + TAP_W'(1);
            end
          end
        end
        STREAM: begin
          if (stream_en) begin
            coef_p1  <= mem[rd_ptr];
            idx_p1   <= rd_ptr;
            vld_p1   <= 1'b1;
            first_p1 <= (rd_ptr == START_IDX);
            last_p1  <= (rd_ptr == END_IDX);
            rd_ptr   <= step_ptr(rd_ptr);
          end else begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign coef_out     = coef_p1;
  assign tap_idx      = idx_p1;
  assign coef_valid   = vld_p1;
  assign coef_first   = first_p1;
  assign coef_last    = last_p1;
  assign kernel_ready = kernel_rdy;

endmodule

// File: tb/tb_kernel_coeff_buffer.sv
// Directed bench for kernel_coeff_buffer: three instances (3 taps forward,
// 4 taps reversed, 1 tap) driven from a vector table plus load/reset sequences.
module tb_kernel_coeff_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ls [3];
  logic        lv [3];
  logic        se [3];
  logic [31:0] ld [3];
  logic [31:0] co [3];
  logic        cv [3];
  logic        cf [3];
  logic        cl [3];
  logic        kr [3];
  logic        lr [3];
  logic [1:0]  ti0;
  logic [1:0]  ti1;
  logic [0:0]  ti2;

  kernel_coeff_buffer #(.DATA_W(32), .TAPS(3), .REVERSE(0)) dut0 (
    .clk(clk), .reset(reset), .load_start(ls[0]), .load_valid(lv[0]),
    .load_data(ld[0]), .load_ready(lr[0]), .stream_en(se[0]), .coef_out(co[0]),
    .coef_valid(cv[0]), .coef_first(cf[0]), .coef_last(cl[0]), .tap_idx(ti0),
    .kernel_ready(kr[0]));

  kernel_coeff_buffer #(.DATA_W(32), .TAPS(4), .REVERSE(1)) dut1 (
    .clk(clk), .reset(reset), .load_start(ls[1]), .load_valid(lv[1]),
    .load_data(ld[1]), .load_ready(lr[1]), .stream_en(se[1]), .coef_out(co[1]),
    .coef_valid(cv[1]), .coef_first(cf[1]), .coef_last(cl[1]), .tap_idx(ti1),
    .kernel_ready(kr[1]));

  kernel_coeff_buffer #(.DATA_W(32), .TAPS(1), .REVERSE(0)) dut2 (
    .clk(clk), .reset(reset), .load_start(ls[2]), .load_valid(lv[2]),
    .load_data(ld[2]), .load_ready(lr[2]), .stream_en(se[2]), .coef_out(co[2]),
    .coef_valid(cv[2]), .coef_first(cf[2]), .coef_last(cl[2]), .tap_idx(ti2),
    .kernel_ready(kr[2]));

  typedef struct {
    int          d;
    bit          se;
    bit          v;
    bit          f;
    bit          l;
    logic [31:0] c;
    int          idx;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic int get_idx(input int d);
    case (d)
      0:       return int'(ti0);
      1:       return int'(ti1);
      default: return int'(ti2);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      ls[k] = 1'b0; lv[k] = 1'b0; se[k] = 1'b0; ld[k] = '0;
    end
  endtask

  task automatic cyc(input int d, input bit s, input bit v, input logic [31:0] dat, input bit e);
    idle();
    ls[d] = s; lv[d] = v; ld[d] = dat; se[d] = e;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int d, input bit e, input bit v, input bit f, input bit l,
                     input logic [31:0] c, input int idx);
    vec_t r;
    r.d = d; r.se = e; r.v = v; r.f = f; r.l = l; r.c = c; r.idx = idx;
    tv.push_back(r);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc(tv[i].d, 1'b0, 1'b0, 32'h0, tv[i].se);
      chk($sformatf("row%0d coef", i),  co[tv[i].d], tv[i].c);
      chk($sformatf("row%0d valid", i), 32'(cv[tv[i].d]), 32'(tv[i].v));
      chk($sformatf("row%0d first", i), 32'(cf[tv[i].d]), 32'(tv[i].f));
      chk($sformatf("row%0d last", i),  32'(cl[tv[i].d]), 32'(tv[i].l));
      chk($sformatf("row%0d idx", i),   32'(get_idx(tv[i].d)), 32'(tv[i].idx));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // rows 0..8: three full forward passes
    for (int p = 0; p < 3; p++) begin
      add(0, 1, 1, 1, 0, 32'h11, 0);
      add(0, 1, 1, 0, 0, 32'h22, 1);
      add(0, 1, 1, 0, 1, 32'h33, 2);
    end
    // rows 9..13: stall pattern 1,0,0,1,1
    add(0, 1, 1, 1, 0, 32'h11, 0);
    add(0, 0, 0, 0, 0, 32'h11, 0);
    add(0, 0, 0, 0, 0, 32'h11, 0);
    add(0, 1, 1, 0, 0, 32'h22, 1);
    add(0, 1, 1, 0, 1, 32'h33, 2);
    // rows 14..16: reloaded kernel
    add(0, 1, 1, 1, 0, 32'hA, 0);
    add(0, 1, 1, 0, 0, 32'hB, 1);
    add(0, 1, 1, 0, 1, 32'hC, 2);
    // row 17: after reset mid-load
    add(0, 1, 1, 1, 0, 32'h7, 0);
    // rows 18..22: reversed 4-tap
    add(1, 1, 1, 1, 0, 32'h4, 3);
    add(1, 1, 1, 0, 0, 32'h3, 2);
    add(1, 1, 1, 0, 0, 32'h2, 1);
    add(1, 1, 1, 0, 1, 32'h1, 0);
    add(1, 1, 1, 1, 0, 32'h4, 3);
    // rows 23..25: single tap
    for (int p = 0; p < 3; p++) add(2, 1, 1, 1, 1, 32'h5A, 0);

    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst coef", co[0], 32'h0);
    chk("rst valid", 32'(cv[0]), 32'h0);
    chk("rst first", 32'(cf[0]), 32'h0);
    chk("rst last", 32'(cl[0]), 32'h0);
    chk("rst idx", 32'(get_idx(0)), 32'h0);
    chk("rst kready", 32'(kr[0]), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst lready", 32'(lr[0]), 32'h1);

    // Load 3 words into the forward 3-tap instance
    cyc(0, 0, 1, 32'h11, 0);
    cyc(0, 0, 1, 32'h22, 0);
    chk("load2 lready", 32'(lr[0]), 32'h1);
    chk("load2 kready", 32'(kr[0]), 32'h0);
    cyc(0, 0, 1, 32'h33, 0);
    chk("load3 lready", 32'(lr[0]), 32'h0);
    chk("load3 kready", 32'(kr[0]), 32'h1);
    run_rows(0, 13);

    // Reload mid-stream: colliding word and stream request are dropped
    cyc(0, 1, 1, 32'hFF, 1);
    chk("reload kready", 32'(kr[0]), 32'h0);
    chk("reload valid", 32'(cv[0]), 32'h0);
    chk("reload lready", 32'(lr[0]), 32'h1);
    chk("reload coef hold", co[0], 32'h33);
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    cyc(0, 0, 1, 32'hC, 0);
    chk("reload kready1", 32'(kr[0]), 32'h1);
    run_rows(14, 16);

    // Reset after 2 of 3 words, asserted away from the clock edge
    cyc(0, 1, 0, 32'h0, 0);
    cyc(0, 0, 1, 32'h1, 0);
    cyc(0, 0, 1, 32'h2, 0);
    idle();
    #2;
    reset = 1'b1;
    #1;
    chk("arst coef", co[0], 32'h0);
    chk("arst idx", 32'(get_idx(0)), 32'h0);
    chk("arst valid", 32'(cv[0]), 32'h0);
    chk("arst kready", 32'(kr[0]), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst lready", 32'(lr[0]), 32'h1);
    cyc(0, 0, 1, 32'h7, 0);
    cyc(0, 0, 1, 32'h8, 0);
    chk("arst load2 kready", 32'(kr[0]), 32'h0);
    cyc(0, 0, 1, 32'h9, 0);
    chk("arst load3 kready", 32'(kr[0]), 32'h1);
    run_rows(17, 17);

    // Reversed 4-tap kernel
    cyc(1, 0, 1, 32'h1, 0);
    cyc(1, 0, 1, 32'h2, 0);
    cyc(1, 0, 1, 32'h3, 0);
    chk("rev load3 kready", 32'(kr[1]), 32'h0);
    cyc(1, 0, 1, 32'h4, 0);
    chk("rev load4 kready", 32'(kr[1]), 32'h1);
    run_rows(18, 22);

    // Single-tap kernel
    cyc(2, 0, 1, 32'h5A, 0);
    chk("taps1 kready", 32'(kr[2]), 32'h1);
    chk("taps1 lready", 32'(lr[2]), 32'h0);
    run_rows(23, 25);

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
